// File: rtl/ofm_compare_engine.sv
`default_nettype none
// ============================================================================
//  Module   : ofm_compare_engine
//  Purpose  : Scans an output-feature-map (OFM) RAM against a golden RAM,
//             LANES words per cycle, and reports how many words differ and
//             the address of the lowest failing word.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst          : clock, synchronous active-high reset
//    start             : one-cycle scan request (ignored while busy)
//    ofm_size          : OFM height/width (square)
//    num_filter        : OFM channel count
//    stop_on_fail      : abort at the first failing group
//    rd_en, rd_addr    : read strobe / lane-0 word address to both RAMs
//    rtl_data          : OFM words, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//    gold_data         : golden words, same layout as rtl_data
//    busy, done, pass  : scan status; pass held until the next start
//    mismatch_count    : saturating count of failing lanes
//    first_fail_addr   : address of the lowest failing word
//    tolerance         : (OFM_CMP_TOLERANCE_EN only) max |rtl - gold|
//  Configuration
//    OFM_CMP_TOLERANCE_EN : when defined, lanes compare as signed values
//                           within 'tolerance'; otherwise exact equality.
// ============================================================================
module ofm_compare_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 16,
    parameter int ADDR_WIDTH = 20,
    parameter int RD_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [8:0]                    ofm_size,
    input  logic [10:0]                   num_filter,
    input  logic                          stop_on_fail,
`ifdef OFM_CMP_TOLERANCE_EN
    input  logic [DATA_WIDTH-1:0]         tolerance,
`endif
    output logic                          rd_en,
    output logic [ADDR_WIDTH-1:0]         rd_addr,
    input  logic [LANES*DATA_WIDTH-1:0]   rtl_data,
    input  logic [LANES*DATA_WIDTH-1:0]   gold_data,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [31:0]                   mismatch_count,
    output logic [ADDR_WIDTH-1:0]         first_fail_addr
);

    localparam int CNT_W = $clog2(LANES + 1);
    localparam logic [ADDR_WIDTH-1:0] C_LANES_ADDR = ADDR_WIDTH'(LANES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CALC   = 3'd1,
        S_READ   = 3'd2,
        S_DRAIN  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                 state_q;
    logic [8:0]             size_q;
    logic [10:0]            nfilt_q;
    logic                   stop_q;
    logic [31:0]            total_q;
    logic [31:0]            groups_q;
    logic [31:0]            issued_q;      // groups already requested
    logic                   rd_en_q;
    logic [ADDR_WIDTH-1:0]  rd_addr_q;
    logic [RD_LATENCY-1:0]  vld_q;         // read-valid delay line
    logic [ADDR_WIDTH-1:0]  addr_dly_q [RD_LATENCY];
    logic                   busy_q;
    logic                   done_q;
    logic                   pass_q;
    logic                   found_q;       // first failure already captured
    logic [31:0]            mm_cnt_q;
    logic [ADDR_WIDTH-1:0]  ffa_q;

    // ------------------------------------------------------------------
    // Scan geometry (from the values latched at start)
    // ------------------------------------------------------------------
    logic [31:0] w_total;
    logic [31:0] w_groups;

    assign w_total  = 32'(size_q) * 32'(size_q) * 32'(nfilt_q);
    assign w_groups = (w_total + 32'(LANES - 1)) / 32'(LANES);

    // ------------------------------------------------------------------
    // Lane comparison on the group whose data returns this cycle
    // ------------------------------------------------------------------
    logic                   w_cmp_vld;
    logic [ADDR_WIDTH-1:0]  w_cmp_addr;
    logic [LANES-1:0]       w_lane_fail;

    assign w_cmp_vld  = vld_q[RD_LATENCY-1];
    assign w_cmp_addr = addr_dly_q[RD_LATENCY-1];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DATA_WIDTH-1:0] w_rtl;
        logic [DATA_WIDTH-1:0] w_gold;
        logic [31:0]           w_addr;
        logic                  w_bad;

        assign w_rtl  = rtl_data[k*DATA_WIDTH +: DATA_WIDTH];
        assign w_gold = gold_data[k*DATA_WIDTH +: DATA_WIDTH];
        assign w_addr = 32'(w_cmp_addr) + 32'(k);

`ifdef OFM_CMP_TOLERANCE_EN
        // One extra bit keeps the signed difference and its magnitude exact.
        logic signed [DATA_WIDTH:0] w_diff;
        logic        [DATA_WIDTH:0] w_abs;
        assign w_diff = $signed({w_rtl[DATA_WIDTH-1], w_rtl})
                      - $signed({w_gold[DATA_WIDTH-1], w_gold});
        assign w_abs  = w_diff[DATA_WIDTH] ? $unsigned(-w_diff) : $unsigned(w_diff);
        assign w_bad  = w_abs > {1'b0, tolerance};
`else
        assign w_bad  = (w_rtl != w_gold);
`endif

        // Lanes past the end of the map belong to the padded last group.
        assign w_lane_fail[k] = w_bad && (w_addr < total_q);
    end

    logic [CNT_W-1:0]       w_fail_cnt;
    logic [ADDR_WIDTH-1:0]  w_fail_idx;
    logic [ADDR_WIDTH-1:0]  w_fail_addr;
    logic                   w_grp_fail;
    logic [32:0]            w_mm_sum;

    // Descending scan so the lowest failing lane is the one left in w_fail_idx.
    always_comb begin
        w_fail_cnt = '0;
        w_fail_idx = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            w_fail_cnt = w_fail_cnt + CNT_W'(w_lane_fail[k]);
            if (w_lane_fail[k]) begin
                w_fail_idx = ADDR_WIDTH'(k);
            end
        end
    end

    assign w_fail_addr = w_cmp_addr + w_fail_idx;
    assign w_grp_fail  = w_cmp_vld && (|w_lane_fail);
    assign w_mm_sum    = {1'b0, mm_cnt_q} + 33'(w_fail_cnt);

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            size_q    <= '0;
            nfilt_q   <= '0;
            stop_q    <= 1'b0;
            total_q   <= '0;
            groups_q  <= '0;
            issued_q  <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            vld_q     <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                addr_dly_q[i] <= '0;
            end
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            found_q   <= 1'b0;
            mm_cnt_q  <= '0;
            ffa_q     <= '0;
        end else begin
            done_q <= 1'b0;

            // Delay line: tracks which cycles carry valid read data.
            vld_q         <= RD_LATENCY'({vld_q, rd_en_q});
            addr_dly_q[0] <= rd_addr_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                addr_dly_q[i] <= addr_dly_q[i-1];
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        size_q   <= ofm_size;
                        nfilt_q  <= num_filter;
                        stop_q   <= stop_on_fail;
                        mm_cnt_q <= '0;
                        ffa_q    <= '0;
                        pass_q   <= 1'b0;
                        found_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_CALC;
                    end
                end

                S_CALC: begin
                    total_q   <= w_total;
                    groups_q  <= w_groups;
                    rd_addr_q <= '0;
                    issued_q  <= 32'd1;
                    if (w_total == 32'd0) begin
                        done_q  <= 1'b1;
                        pass_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end else begin
                        rd_en_q <= 1'b1;
                        state_q <= S_READ;
                    end
                end

                S_READ: begin
                    if (issued_q == groups_q) begin
                        rd_en_q <= 1'b0;
                        state_q <= S_DRAIN;
                    end else begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= rd_addr_q + C_LANES_ADDR;
                        issued_q  <= issued_q + 32'd1;
                    end
                end

                S_DRAIN: begin
                    if (vld_q == '0) begin
                        done_q  <= 1'b1;
                        pass_q  <= (mm_cnt_q == 32'd0);
                        state_q <= S_FINISH;
                    end
                end

                S_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // Group results; placed after the case so an abort overrides
            // the read sequencing decided above.
            if (w_grp_fail) begin
                mm_cnt_q <= w_mm_sum[32] ? 32'hFFFF_FFFF : w_mm_sum[31:0];
                if (!found_q) begin
                    found_q <= 1'b1;
                    ffa_q   <= w_fail_addr;
                end
                if (stop_q) begin
                    rd_en_q <= 1'b0;
                    vld_q   <= '0;       // discard everything still in flight
                    state_q <= S_DRAIN;
                end
            end
        end
    end

    assign rd_en           = rd_en_q;
    assign rd_addr         = rd_addr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign mismatch_count  = mm_cnt_q;
    assign first_fail_addr = ffa_q;

endmodule

`default_nettype wire

// File: tb/tb_ofm_compare_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ofm_compare_engine
//  Purpose  : Self-checking bench for ofm_compare_engine. Two word-addressed
//             RAM models feed the DUT; a reference model walks the RAMs to
//             predict each scan's result, pushed to a scoreboard at start
//             and popped when done pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ofm_compare_engine;

    localparam int DW        = 16;
    localparam int LN        = 16;
    localparam int AW        = 20;
    localparam int RDL       = 1;
    localparam int MEM_WORDS = 16384;
    localparam int TIMEOUT   = 20000;

    typedef struct packed {
        logic          pass;
        logic [31:0]   mm;
        logic [AW-1:0] ffa;
        logic [31:0]   reads;
    } res_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [8:0]     ofm_size = '0;
    logic [10:0]    num_filter = '0;
    logic           stop_on_fail = 1'b0;
`ifdef OFM_CMP_TOLERANCE_EN
    logic [DW-1:0]  tolerance = '0;
`endif
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [LN*DW-1:0] rtl_data;
    logic [LN*DW-1:0] gold_data;
    logic           busy;
    logic           done;
    logic           pass;
    logic [31:0]    mismatch_count;
    logic [AW-1:0]  first_fail_addr;

    ofm_compare_engine #(
        .DATA_WIDTH (DW),
        .LANES      (LN),
        .ADDR_WIDTH (AW),
        .RD_LATENCY (RDL)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .ofm_size        (ofm_size),
        .num_filter      (num_filter),
        .stop_on_fail    (stop_on_fail),
`ifdef OFM_CMP_TOLERANCE_EN
        .tolerance       (tolerance),
`endif
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rtl_data        (rtl_data),
        .gold_data       (gold_data),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .mismatch_count  (mismatch_count),
        .first_fail_addr (first_fail_addr)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // RAM models with RDL-cycle read latency
    // ------------------------------------------------------------------
    logic [DW-1:0]    rtl_mem  [MEM_WORDS];
    logic [DW-1:0]    gold_mem [MEM_WORDS];
    logic [LN*DW-1:0] rtl_pipe [RDL];
    logic [LN*DW-1:0] gold_pipe[RDL];

    always @(posedge clk) begin
        for (int k = 0; k < LN; k++) begin
            rtl_pipe[0][k*DW +: DW]  <= rtl_mem[(int'(rd_addr) + k) % MEM_WORDS];
            gold_pipe[0][k*DW +: DW] <= gold_mem[(int'(rd_addr) + k) % MEM_WORDS];
        end
        for (int i = 1; i < RDL; i++) begin
            rtl_pipe[i]  <= rtl_pipe[i-1];
            gold_pipe[i] <= gold_pipe[i-1];
        end
    end

    assign rtl_data  = rtl_pipe[RDL-1];
    assign gold_data = gold_pipe[RDL-1];

    // ------------------------------------------------------------------
    // Read monitor: per-scan read count, highest address, address order
    // ------------------------------------------------------------------
    int            mon_reads = 0;
    logic [AW-1:0] mon_max   = '0;
    int            addr_err  = 0;
    int            done_cnt  = 0;

    always @(posedge clk) begin
        if (rst || (start && !busy)) begin
            mon_reads <= 0;
            mon_max   <= '0;
        end else if (rd_en) begin
            if (rd_addr !== AW'(mon_reads * LN)) addr_err <= addr_err + 1;
            mon_reads <= mon_reads + 1;
            if (rd_addr > mon_max) mon_max <= rd_addr;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    // ------------------------------------------------------------------
    // Scoreboard and reference model
    // ------------------------------------------------------------------
    res_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic bit word_bad(int a);
`ifdef OFM_CMP_TOLERANCE_EN
        int d;
        d = int'($signed(rtl_mem[a])) - int'($signed(gold_mem[a]));
        if (d < 0) d = -d;
        return d > int'(tolerance);
`else
        return rtl_mem[a] !== gold_mem[a];
`endif
    endfunction

    function automatic res_t model_scan(int sz, int nf, bit stp);
        res_t r;
        int   total;
        int   groups;
        int   gfail;
        total  = sz * sz * nf;
        groups = (total + LN - 1) / LN;
        gfail  = -1;
        r      = '0;
        r.reads = 32'(groups);
        for (int a = 0; a < total; a++) begin
            if (word_bad(a)) begin
                if (gfail < 0) begin
                    gfail = a / LN;
                    r.ffa = AW'(a);
                end
                if (!stp || (a / LN) == gfail) r.mm = r.mm + 32'd1;
            end
        end
        if (stp && gfail >= 0 && gfail + RDL + 1 < groups) r.reads = 32'(gfail + RDL + 1);
        r.pass = (r.mm == 32'd0);
        return r;
    endfunction

    task automatic fill_mem();
        for (int a = 0; a < MEM_WORDS; a++) begin
            rtl_mem[a]  = DW'($urandom);
            gold_mem[a] = rtl_mem[a];
        end
    endtask

    // Called at a negedge; start is high for exactly one clock.
    task automatic launch_scan(input int sz, input int nf, input bit stp);
        sb.push_back(model_scan(sz, nf, stp));
        ofm_size     = 9'(sz);
        num_filter   = 11'(nf);
        stop_on_fail = stp;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic wait_done(output bit seen, output res_t got);
        seen = 1'b0;
        got  = '0;
        for (int i = 0; i < TIMEOUT && !seen; i++) begin
            if (done) begin
                seen      = 1'b1;
                got.pass  = pass;
                got.mm    = mismatch_count;
                got.ffa   = first_fail_addr;
                got.reads = 32'(mon_reads);
            end else begin
                @(negedge clk);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, done, pass, rd_en, mismatch_count, first_fail_addr, rd_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset.in_reset got busy=%0b done=%0b pass=%0b rd_en=%0b mm=%0d ffa=%0d rd_addr=%0d exp all 0",
                     busy, done, pass, rd_en, mismatch_count, first_fail_addr, rd_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy, done, rd_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset.idle got busy=%0b done=%0b rd_en=%0b exp 0 0 0", busy, done, rd_en);
        end
    endtask

    task automatic test_clean();
        bit   seen;
        res_t got, exp;
        int   d0, a0;
        fill_mem();
        d0 = done_cnt;
        a0 = addr_err;
        launch_scan(26, 16, 1'b0);
        n_vec++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clean.busy got=%0b exp=1", busy);
        end
        wait_done(seen, got);
        exp = sb.pop_front();
        n_vec++;
        if (!seen || got !== exp) begin
            n_fail++;
            $display("FAIL clean.result seen=%0b got pass=%0b mm=%0d ffa=%0d reads=%0d exp pass=%0b mm=%0d ffa=%0d reads=%0d",
                     seen, got.pass, got.mm, got.ffa, got.reads, exp.pass, exp.mm, exp.ffa, exp.reads);
        end
        n_vec++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clean.busy_in_finish got=%0b exp=1", busy);
        end
        @(negedge clk);
        n_vec++;
        if (done_cnt - d0 != 1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL clean.done_once got pulses=%0d busy=%0b done=%0b exp 1 0 0", done_cnt - d0, busy, done);
        end
        n_vec++;
        if (addr_err != a0) begin
            n_fail++;
            $display("FAIL clean.addr_seq got bad_addrs=%0d exp=0", addr_err - a0);
        end
    endtask

    task automatic test_stop_on_fail();
        bit   seen;
        res_t got, exp;
        fill_mem();
        gold_mem[5000] = rtl_mem[5000] ^ 16'h0001;
        @(negedge clk);
        launch_scan(26, 16, 1'b1);
        wait_done(seen, got);
        exp = sb.pop_front();
        n_vec++;
        if (!seen || got !== exp) begin
            n_fail++;
            $display("FAIL stop.result seen=%0b got pass=%0b mm=%0d ffa=%0d reads=%0d exp pass=%0b mm=%0d ffa=%0d reads=%0d",
                     seen, got.pass, got.mm, got.ffa, got.reads, exp.pass, exp.mm, exp.ffa, exp.reads);
        end
        n_vec++;
        if (mon_max > AW'(4992 + LN * RDL)) begin
            n_fail++;
            $display("FAIL stop.max_addr got=%0d exp<=%0d", mon_max, 4992 + LN * RDL);
        end
        @(negedge clk);
    endtask

    task automatic test_multi_fault();
        bit   seen;
        res_t got, exp;
        fill_mem();
        gold_mem[17]    = ~rtl_mem[17];
        gold_mem[18]    = rtl_mem[18] + 16'd1;
        gold_mem[10815] = rtl_mem[10815] ^ 16'h8000;
        @(negedge clk);
        launch_scan(26, 16, 1'b0);
        // A start while busy must not disturb the scan in progress.
        repeat (10) @(negedge clk);
        ofm_size = 9'd5; num_filter = 11'd1; stop_on_fail = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(seen, got);
        exp = sb.pop_front();
        n_vec++;
        if (!seen || got !== exp) begin
            n_fail++;
            $display("FAIL multi.result seen=%0b got pass=%0b mm=%0d ffa=%0d reads=%0d exp pass=%0b mm=%0d ffa=%0d reads=%0d",
                     seen, got.pass, got.mm, got.ffa, got.reads, exp.pass, exp.mm, exp.ffa, exp.reads);
        end
        @(negedge clk);
    endtask

    task automatic test_partial_group();
        bit   seen;
        res_t got, exp;
        fill_mem();
        for (int a = 25; a < 32; a++) gold_mem[a] = ~rtl_mem[a];
        @(negedge clk);
        launch_scan(5, 1, 1'b0);
        wait_done(seen, got);
        exp = sb.pop_front();
        n_vec++;
        if (!seen || got !== exp) begin
            n_fail++;
            $display("FAIL partial.result seen=%0b got pass=%0b mm=%0d ffa=%0d reads=%0d exp pass=%0b mm=%0d ffa=%0d reads=%0d",
                     seen, got.pass, got.mm, got.ffa, got.reads, exp.pass, exp.mm, exp.ffa, exp.reads);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit   seen;
        res_t got, exp;
        fill_mem();
        gold_mem[3] = ~rtl_mem[3];
        @(negedge clk);
        // Empty map: straight to FINISH with a pass.
        launch_scan(4, 0, 1'b0);
        wait_done(seen, got);
        exp = sb.pop_front();
        n_vec++;
        if (!seen || got !== exp) begin
            n_fail++;
            $display("FAIL b2b.empty seen=%0b got pass=%0b mm=%0d reads=%0d exp pass=%0b mm=%0d reads=%0d",
                     seen, got.pass, got.mm, got.reads, exp.pass, exp.mm, exp.reads);
        end
        repeat (5) @(negedge clk);
        n_vec++;
        if (pass !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b.pass_held got=%0b exp=1", pass);
        end
        launch_scan(5, 1, 1'b0);
        n_vec++;
        if (pass !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b.pass_cleared got=%0b exp=0", pass);
        end
        wait_done(seen, got);
        exp = sb.pop_front();
        n_vec++;
        if (!seen || got !== exp) begin
            n_fail++;
            $display("FAIL b2b.second seen=%0b got pass=%0b mm=%0d ffa=%0d reads=%0d exp pass=%0b mm=%0d ffa=%0d reads=%0d",
                     seen, got.pass, got.mm, got.ffa, got.reads, exp.pass, exp.mm, exp.ffa, exp.reads);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_scan();
        bit   seen;
        bit   reached;
        res_t got, exp;
        fill_mem();
        gold_mem[40] = ~rtl_mem[40];
        @(negedge clk);
        launch_scan(26, 16, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < TIMEOUT && !reached; i++) begin
            if (mon_reads >= 100) reached = 1'b1;
            else @(negedge clk);
        end
        n_vec++;
        if (!reached) begin
            n_fail++;
            $display("FAIL midrst.reach got reads=%0d exp>=100", mon_reads);
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({busy, done, pass, rd_en, mismatch_count, first_fail_addr, rd_addr} !== '0) begin
            n_fail++;
            $display("FAIL midrst.outputs got busy=%0b done=%0b pass=%0b rd_en=%0b mm=%0d ffa=%0d rd_addr=%0d exp all 0",
                     busy, done, pass, rd_en, mismatch_count, first_fail_addr, rd_addr);
        end
        void'(sb.pop_front());   // aborted scan never reports
        rst = 1'b0;
        gold_mem[40] = rtl_mem[40];
        launch_scan(26, 16, 1'b0);   // start in the first cycle out of reset
        n_vec++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst.restart_busy got=%0b exp=1", busy);
        end
        wait_done(seen, got);
        exp = sb.pop_front();
        n_vec++;
        if (!seen || got !== exp) begin
            n_fail++;
            $display("FAIL midrst.restart seen=%0b got pass=%0b mm=%0d ffa=%0d reads=%0d exp pass=%0b mm=%0d ffa=%0d reads=%0d",
                     seen, got.pass, got.mm, got.ffa, got.reads, exp.pass, exp.mm, exp.ffa, exp.reads);
        end
        @(negedge clk);
    endtask

`ifdef OFM_CMP_TOLERANCE_EN
    task automatic test_tolerance();
        bit   seen;
        res_t got, exp;
        fill_mem();
        tolerance   = 16'd2;
        rtl_mem[0]  = 16'hFFFD;  gold_mem[0] = 16'hFFFF;   // -3 vs -1: within
        rtl_mem[1]  = 16'h7FFF;  gold_mem[1] = 16'h8000;   // extreme span: fails
        @(negedge clk);
        launch_scan(1, 2, 1'b0);
        wait_done(seen, got);
        exp = sb.pop_front();
        n_vec++;
        if (!seen || got !== exp) begin
            n_fail++;
            $display("FAIL tol.result seen=%0b got pass=%0b mm=%0d ffa=%0d exp pass=%0b mm=%0d ffa=%0d",
                     seen, got.pass, got.mm, got.ffa, exp.pass, exp.mm, exp.ffa);
        end
        tolerance = '0;
        @(negedge clk);
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_clean();
        test_stop_on_fail();
        test_multi_fault();
        test_partial_group();
        test_back_to_back();
        test_reset_mid_scan();
`ifdef OFM_CMP_TOLERANCE_EN
        test_tolerance();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ofm_compare_engine.md
OFM_COMPARE_ENGINE -- requirements
Module: ofm_compare_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: bits per OFM word.
REQ-002 SHALL have parameter LANES, default 16: words compared per cycle (INOUT_WIDTH/DATA_WIDTH).
REQ-003 SHALL have parameter ADDR_WIDTH, default 20: word-address width.
REQ-004 SHALL have parameter RD_LATENCY, default 1: cycles from rd_en to valid read data (range 1..4).
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: one-cycle scan request.
REQ-008 SHALL have port ofm_size, input, 9: OFM height and width (square).
REQ-009 SHALL have port num_filter, input, 11: OFM channel count.
REQ-010 SHALL have port stop_on_fail, input, 1: 1 = abort at the first failing group; sampled on start.
REQ-011 SHALL have port rd_en, output, 1: read strobe to the OFM and golden RAMs.
REQ-012 SHALL have port rd_addr, output, ADDR_WIDTH: word address of lane 0 of the group.
REQ-013 SHALL have port rtl_data, input, LANES*DATA_WIDTH: OFM words; lane k sits at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL have port gold_data, input, LANES*DATA_WIDTH: golden words, same lane layout as rtl_data.
REQ-015 SHALL have port busy, output, 1: scan in progress.
REQ-016 SHALL have port done, output, 1: one-cycle pulse marking scan end.
REQ-017 SHALL have port pass, output, 1: result of the last scan, held until the next start.
REQ-018 SHALL have port mismatch_count, output, 32: number of failing lanes.
REQ-019 SHALL have port first_fail_addr, output, ADDR_WIDTH: address of the lowest failing word.

Function
REQ-020 SHALL sample ofm_size, num_filter and stop_on_fail on start in IDLE; start while busy SHALL be ignored.
REQ-021 SHALL use FSM states IDLE -> CALC -> READ -> DRAIN -> FINISH -> IDLE.
REQ-022 SHALL, in CALC (1 cycle), register total = ofm_size*ofm_size*num_filter and groups = ceil(total/LANES).
REQ-023 SHALL, when total = 0, go CALC -> FINISH with pass=1 and mismatch_count=0.
REQ-024 SHALL, in READ, assert rd_en every cycle with rd_addr = g*LANES for g = 0..groups-1, then enter DRAIN.
REQ-025 SHALL compare each group in the cycle its data returns, RD_LATENCY cycles after the matching rd_en, using a valid/address delay line of depth RD_LATENCY.
REQ-026 SHALL mask off lanes with address >= total in the last group; masked lanes never fail.
REQ-027 SHALL add the number of failing lanes in a group to mismatch_count, saturating at 0xFFFFFFFF.
REQ-028 SHALL capture first_fail_addr only for the first failing group, using that group's lowest failing lane address.
REQ-029 SHALL, when stop_on_fail=1 and a group fails, deassert rd_en on the next cycle, enter DRAIN, and discard all data still in flight.
REQ-030 SHALL leave DRAIN once no reads are outstanding; FINISH SHALL last 1 cycle, pulse done, and set pass = (mismatch_count == 0).
REQ-031 SHALL keep busy high from the cycle after an accepted start through FINISH inclusive.
REQ-032 SHALL, on accepted start, clear mismatch_count, first_fail_addr and pass.

Reset
REQ-033 SHALL, on rst, set the state to IDLE and all outputs to 0, including while a scan is mid-operation; in-flight data SHALL be dropped.
REQ-034 SHALL accept start on the first cycle after rst deasserts.

Configuration
REQ-035 SHALL, with OFM_CMP_TOLERANCE_EN defined, add input port tolerance (DATA_WIDTH bits, unsigned); a lane SHALL pass when |signed(rtl) - signed(gold)| <= tolerance, computed at DATA_WIDTH+1 bits with no overflow.
REQ-036 SHALL, without OFM_CMP_TOLERANCE_EN, omit the tolerance port and pass a lane only on exact bit equality.

Verification
REQ-037 SHALL cover a clean scan: ofm_size=26, num_filter=16, LANES=16, identical RAMs -> 676 rd_en cycles, done once, pass=1, mismatch_count=0.
REQ-038 SHALL cover stop-on-fail: same dimensions, word 5000 corrupted, stop_on_fail=1 -> first_fail_addr=5000, mismatch_count=1, pass=0, no rd_addr issued beyond 4992+RD_LATENCY groups.
REQ-039 SHALL cover a full scan with multiple faults: words 17, 18 and 10815 corrupted, stop_on_fail=0 -> mismatch_count=3, first_fail_addr=17, 676 reads issued.
REQ-040 SHALL cover a partial last group: ofm_size=5, num_filter=1 -> 2 groups; garbage in words 25..31 -> pass=1.
REQ-041 SHALL cover reset mid-scan: rst asserted at group 100 -> next cycle busy=0, all outputs 0; a following start SHALL complete normally.
REQ-042 SHALL cover tolerance with OFM_CMP_TOLERANCE_EN defined: tolerance=2, rtl=-3 vs gold=-1 -> pass; rtl=0x7FFF vs gold=0x8000 -> fail.
